// File: rtl/fftl_pkg.sv
// fftl_pkg: shared state/decision types and reset constant for the fine-frequency tracking loop
package fftl_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, TRACK, LOCKED} state_t;
  typedef enum logic [1:0] {HOLD, INC, DEC} dec_t;
  function automatic logic [31:0] ctrl_rst(input int w);
    return 32'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/fftl_sync2.sv
// fftl_sync2: two-flop synchroniser into the clk_out domain
module fftl_sync2 (
  input  logic clk_out,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_m;
  always_ff @(posedge clk_out or posedge rst)
    if (rst) {o_q, r_m} <= '0;
    else {o_q, r_m} <= {r_m, i_d};
endmodule

// File: rtl/fftl_tracker.sv
// fftl_tracker: second-generation fine-frequency tracking loop with windowed hit statistics and lock detect
module fftl_tracker
  import fftl_pkg::*;
#(
  parameter int CTRL_W   = 13,
  parameter int DIV_W    = 6,
  parameter int ACC_W    = 25,
  parameter int WIN_W    = 5,
  parameter int STEP_W   = 4,
  parameter int DB_W     = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              ref_clk,
  input  logic              sample_hit,
  input  logic              fftl_en,
  input  logic [DIV_W-1:0]  div_ratio_half,
  input  logic [WIN_W-1:0]  win_sel,
  input  logic [STEP_W-1:0] step_size,
  input  logic [DB_W-1:0]   deadband,
  input  logic [CTRL_W-1:0] manual_ctrl,
  output logic              out_star,
  output logic [CTRL_W-1:0] ctrl_final,
  output logic              locked,
  output logic              update_pulse,
  output logic              sat_hi,
  output logic              sat_lo
);
  localparam int HC_W = $clog2(LOCK_CNT + 1);
  logic w_ref_s, w_hit_s, r_ref_d, w_rise, w_fall, w_win_end, w_apply;
  logic r_sync, r_star, r_upd, r_sat_hi, r_sat_lo;
  logic [DIV_W-1:0] r_cnt, w_n_m1;
  logic [ACC_W-1:0] r_clean, r_error, r_win, w_clean_nx, w_error_nx, w_win_len;
  logic [31:0] w_sh;
  logic signed [ACC_W:0] w_d, w_db;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W:0] w_inc, w_dec;
  logic [HC_W-1:0] r_hold;
  state_t r_state, w_state;
  dec_t w_sel;

  fftl_sync2 u_ref (.clk_out(clk_out), .rst(rst), .i_d(ref_clk), .o_q(w_ref_s));
  fftl_sync2 u_hit (.clk_out(clk_out), .rst(rst), .i_d(sample_hit), .o_q(w_hit_s));

  assign w_rise = w_ref_s & ~r_ref_d;
  assign w_fall = ~w_ref_s & r_ref_d;
  assign w_n_m1 = (div_ratio_half < DIV_W'(2)) ? DIV_W'(1) : div_ratio_half - DIV_W'(1);
  assign w_clean_nx = (w_rise && w_hit_s && !(&r_clean)) ? r_clean + ACC_W'(1) : r_clean;
  assign w_error_nx = (w_fall && w_hit_s && !(&r_error)) ? r_error + ACC_W'(1) : r_error;
  assign w_sh = (win_sel == '0) ? 32'd1 : (32'(win_sel) > 32'(ACC_W - 1)) ? 32'(ACC_W - 1) : 32'(win_sel);
  assign w_win_len = ACC_W'(1) << w_sh;
  assign w_win_end = w_rise && (r_win + ACC_W'(1) >= w_win_len);
  // decision sees the clean count including the sample taken on the window-closing edge
  assign w_d = $signed({1'b0, w_clean_nx}) - $signed({1'b0, r_error});
  assign w_db = $signed((ACC_W + 1)'(deadband));
  assign w_sel = (w_d > w_db) ? DEC : (w_d < -w_db) ? INC : HOLD;
  assign w_inc = {1'b0, r_ctrl} + (CTRL_W + 1)'(step_size);
  assign w_dec = {1'b0, r_ctrl} - (CTRL_W + 1)'(step_size);

  always_comb begin
    w_state = r_state;
    w_apply = 1'b0;
    if (!fftl_en) w_state = IDLE;
    else
      case (r_state)
        IDLE:   w_state = SETTLE;
        SETTLE: if (w_win_end) w_state = TRACK;
        TRACK:
          if (w_win_end) begin
            w_apply = 1'b1;
            if (w_sel == HOLD && 32'(r_hold) + 32'd1 >= 32'(LOCK_CNT)) w_state = LOCKED;
          end
        LOCKED:
          if (w_win_end && w_sel != HOLD) begin
            w_apply = 1'b1;
            w_state = TRACK;
          end
        default: w_state = IDLE;
      endcase
  end

  always_ff @(posedge clk_out or posedge rst)
    if (rst) begin
      r_ref_d  <= 1'b0;
      r_sync   <= 1'b0;
      r_cnt    <= '0;
      r_star   <= 1'b0;
      r_state  <= IDLE;
      r_upd    <= 1'b0;
      r_clean  <= '0;
      r_error  <= '0;
      r_win    <= '0;
      r_hold   <= '0;
      r_ctrl   <= CTRL_W'(ctrl_rst(CTRL_W));
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      r_ref_d <= w_ref_s;
      r_sync  <= r_sync | w_rise;
      r_star  <= r_sync && (r_cnt >= w_n_m1);
      if (r_sync) r_cnt <= (r_cnt >= w_n_m1) ? '0 : r_cnt + DIV_W'(1);
      r_state <= w_state;
      r_upd   <= w_apply;
      if (r_state == IDLE || w_win_end) begin
        r_clean <= '0;
        r_error <= '0;
        r_win   <= '0;
      end else begin
        r_clean <= w_clean_nx;
        r_error <= w_error_nx;
        r_win   <= r_win + ACC_W'(w_rise);
      end
      r_hold <= (r_state == IDLE) ? '0 : !w_apply ? r_hold : (w_sel == HOLD) ? r_hold + HC_W'(1) : '0;
      r_ctrl <= (r_state == IDLE) ? manual_ctrl : !w_apply ? r_ctrl :
                (w_sel == INC) ? (w_inc[CTRL_W] ? '1 : w_inc[CTRL_W-1:0]) :
                (w_sel == DEC) ? (w_dec[CTRL_W] ? '0 : w_dec[CTRL_W-1:0]) : r_ctrl;
      r_sat_hi <= (r_state == IDLE && w_state == SETTLE) ? 1'b0 : r_sat_hi | (w_apply && w_sel == INC && w_inc[CTRL_W]);
      r_sat_lo <= (r_state == IDLE && w_state == SETTLE) ? 1'b0 : r_sat_lo | (w_apply && w_sel == DEC && w_dec[CTRL_W]);
    end

  assign out_star     = r_star;
  assign ctrl_final   = fftl_en ? r_ctrl : manual_ctrl;
  assign locked       = (r_state == LOCKED);
  assign update_pulse = r_upd;
  assign sat_hi       = r_sat_hi;
  assign sat_lo       = r_sat_lo;
endmodule

// File: tb/tb_fftl_tracker.sv
// tb_fftl_tracker: directed stimulus checked every cycle against a window-level behavioural model
module tb_fftl_tracker;
  localparam int M_IDLE = 0, M_SETTLE = 1, M_TRACK = 2, M_LOCKED = 3;
  logic clk_out = 1'b0, rst = 1'b1, ref_clk = 1'b0, sample_hit = 1'b0, fftl_en = 1'b0;
  logic [5:0] div_ratio_half = 6'd4;
  logic [4:0] win_sel = 5'd2;
  logic [3:0] step_size = 4'd3, deadband = 4'd0;
  logic [12:0] manual_ctrl = 13'h0123;
  logic out_star, locked, update_pulse, sat_hi, sat_lo;
  logic [12:0] ctrl_final;
  int checks = 0, errors = 0, star_cnt = 0, upd_cnt = 0;
  int m_mode, m_ctrl, m_clean, m_err, m_win, m_holds, m_cnt;
  bit m_sync, m_star, m_upd, m_shi, m_slo;
  bit x[4], h[4];

  always #5 clk_out = ~clk_out;

  fftl_tracker dut (
    .clk_out(clk_out), .rst(rst), .ref_clk(ref_clk), .sample_hit(sample_hit), .fftl_en(fftl_en),
    .div_ratio_half(div_ratio_half), .win_sel(win_sel), .step_size(step_size), .deadband(deadband),
    .manual_ctrl(manual_ctrl), .out_star(out_star), .ctrl_final(ctrl_final), .locked(locked),
    .update_pulse(update_pulse), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ctrl = 13'h1000; m_clean = 0; m_err = 0; m_win = 0; m_holds = 0; m_cnt = 0;
    m_sync = 0; m_star = 0; m_upd = 0; m_shi = 0; m_slo = 0;
    for (int i = 0; i < 4; i++) begin x[i] = 0; h[i] = 0; end
  endtask

  // one clk_out cycle of the loop as seen from outside: ref edges take effect two samples later
  task automatic model_step();
    bit rise, fall, hb;
    int n, sh, w, d, db;
    for (int i = 3; i > 0; i--) begin x[i] = x[i-1]; h[i] = h[i-1]; end
    x[0] = ref_clk; h[0] = sample_hit;
    rise = x[2] && !x[3]; fall = !x[2] && x[3]; hb = h[2];
    m_star = 0;
    if (m_sync) begin
      n = (div_ratio_half < 2) ? 2 : int'(div_ratio_half);
      if (m_cnt >= n - 1) begin m_star = 1; m_cnt = 0; end else m_cnt++;
    end
    if (rise) m_sync = 1;
    m_upd = 0;
    if (m_mode == M_IDLE) begin
      m_ctrl = manual_ctrl; m_clean = 0; m_err = 0; m_win = 0; m_holds = 0;
      if (fftl_en) begin m_mode = M_SETTLE; m_shi = 0; m_slo = 0; end
    end else if (!fftl_en) m_mode = M_IDLE;
    else begin
      if (fall && hb) m_err++;
      if (rise) begin
        if (hb) m_clean++;
        m_win++;
        sh = (win_sel < 1) ? 1 : (win_sel > 24) ? 24 : int'(win_sel);
        w = 1 << sh;
        if (m_win >= w) begin
          d = m_clean - m_err; db = deadband;
          m_clean = 0; m_err = 0; m_win = 0;
          if (m_mode == M_SETTLE) m_mode = M_TRACK;
          else if (d > db || d < -db) begin
            m_upd = 1; m_holds = 0; m_mode = M_TRACK;
            if (d > db) begin
              m_ctrl -= int'(step_size);
              if (m_ctrl < 0) begin m_ctrl = 0; m_slo = 1; end
            end else begin
              m_ctrl += int'(step_size);
              if (m_ctrl > 8191) begin m_ctrl = 8191; m_shi = 1; end
            end
          end else if (m_mode == M_TRACK) begin
            m_upd = 1; m_holds++;
            if (m_holds >= 8) m_mode = M_LOCKED;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_out);
    model_step();
    chk("ctrl_final", ctrl_final, fftl_en ? m_ctrl : int'(manual_ctrl));
    chk("locked", locked, m_mode == M_LOCKED);
    chk("update_pulse", update_pulse, m_upd);
    chk("out_star", out_star, m_star);
    chk("sat_hi", sat_hi, m_shi);
    chk("sat_lo", sat_lo, m_slo);
    star_cnt += out_star;
    upd_cnt += update_pulse;
  endtask

  task automatic ref_cycle(input bit hr, input bit hf);
    ref_clk = 1'b1; sample_hit = hr;
    repeat (4) tick();
    ref_clk = 1'b0; sample_hit = hf;
    repeat (4) tick();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl_final", ctrl_final, 13'h1000);
    chk("rst_locked", locked, 0);
    chk("rst_update_pulse", update_pulse, 0);
    chk("rst_out_star", out_star, 0);
    @(negedge clk_out);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_out);
    chk("reset_manual_mux", ctrl_final, 13'h0123);
    chk("reset_sat_hi", sat_hi, 0);
    rst = 1'b0;
    // manual mode and out_star cadence
    ref_cycle(0, 0);
    star_cnt = 0;
    repeat (24) tick();
    chk("out_star_count_div4", star_cnt, 6);
    // enable: settle window then DEC by 3 per window
    fftl_en = 1'b1;
    upd_cnt = 0;
    repeat (4) ref_cycle(1, 0);
    chk("settle_no_update_ctrl", ctrl_final, 13'h0123);
    chk("settle_no_update_pulse", upd_cnt, 0);
    repeat (8) ref_cycle(1, 0);
    chk("two_dec_ctrl", ctrl_final, 13'h011D);
    chk("two_dec_pulses", upd_cnt, 2);
    // balanced windows lock after eight holds
    repeat (7) begin ref_cycle(1, 1); ref_cycle(0, 0); ref_cycle(1, 1); ref_cycle(0, 0); end
    chk("seven_holds_unlocked", locked, 0);
    ref_cycle(1, 1); ref_cycle(0, 0); ref_cycle(1, 1); ref_cycle(0, 0);
    chk("eight_holds_locked", locked, 1);
    repeat (4) ref_cycle(1, 0);
    chk("unlock_locked", locked, 0);
    chk("unlock_ctrl", ctrl_final, 13'h011A);
    // saturation high
    fftl_en = 1'b0; manual_ctrl = 13'h1FFE; step_size = 4'd5;
    repeat (2) tick();
    fftl_en = 1'b1;
    repeat (4) ref_cycle(0, 1);
    repeat (4) ref_cycle(0, 1);
    chk("sat_hi_ctrl", ctrl_final, 13'h1FFF);
    chk("sat_hi_flag", sat_hi, 1);
    repeat (4) ref_cycle(0, 1);
    chk("sat_hi_held", sat_hi, 1);
    // saturation low
    fftl_en = 1'b0; manual_ctrl = 13'h0002;
    repeat (2) tick();
    fftl_en = 1'b1;
    repeat (4) ref_cycle(0, 0);
    chk("sat_hi_cleared", sat_hi, 0);
    repeat (4) ref_cycle(1, 0);
    chk("sat_lo_ctrl", ctrl_final, 0);
    chk("sat_lo_flag", sat_lo, 1);
    // deadband 2: +-2 holds, +3 steps down
    fftl_en = 1'b0; manual_ctrl = 13'h0100; deadband = 4'd2; div_ratio_half = 6'd1;
    repeat (2) tick();
    fftl_en = 1'b1;
    repeat (4) ref_cycle(0, 0);
    ref_cycle(1, 0); ref_cycle(1, 0); ref_cycle(0, 0); ref_cycle(0, 0);
    chk("db_plus2_hold", ctrl_final, 13'h0100);
    div_ratio_half = 6'd7;
    ref_cycle(0, 1); ref_cycle(0, 1); ref_cycle(0, 0); ref_cycle(0, 0);
    chk("db_minus2_hold", ctrl_final, 13'h0100);
    ref_cycle(1, 0); ref_cycle(1, 0); ref_cycle(1, 0); ref_cycle(0, 0);
    chk("db_plus3_dec", ctrl_final, 13'h00FB);
    // asynchronous reset mid-window with the loop still enabled
    ref_cycle(1, 0); ref_cycle(1, 0);
    mid_reset();
    upd_cnt = 0;
    repeat (4) ref_cycle(1, 0);
    chk("post_rst_settle_ctrl", ctrl_final, 13'h0100);
    chk("post_rst_settle_pulses", upd_cnt, 0);
    repeat (4) ref_cycle(1, 0);
    chk("post_rst_first_update", ctrl_final, 13'h00FB);
    chk("post_rst_pulses", upd_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
